// File: rtl/sys_bridge_n.sv
// CPU-to-peripheral bridge: decodes NDEV 16-byte windows and runs a registered
// request/ready transaction with a timeout. Also synchronises device IRQs into HWInt.
module sys_bridge_n #(
    parameter int          NDEV      = 2,
    parameter logic [31:0] BASE      = 32'h0000_7F00,
    parameter int          DEV_WORDS = 3,
    parameter int          TIMEOUT   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pr_req,
    input  logic               pr_we,
    input  logic [29:0]        pr_addr,
    input  logic [31:0]        pr_wd,
    input  logic [3:0]         pr_be,
    output logic [31:0]        pr_rd,
    output logic               pr_ready,
    output logic               pr_err,
    output logic [NDEV-1:0]    dev_sel,
    output logic               dev_we,
    output logic [1:0]         dev_addr,
    output logic [31:0]        dev_wd,
    output logic [3:0]         dev_be,
    input  logic [NDEV*32-1:0] dev_rd,
    input  logic [NDEV-1:0]    dev_ready,
    input  logic [NDEV-1:0]    irq,
    output logic [5:0]         hw_int
);
    localparam int          IW = (NDEV > 1) ? $clog2(NDEV) : 1;
    localparam int          CW = $clog2(TIMEOUT);
    // 33-bit bounds so a window ending at the top of memory cannot wrap
    localparam logic [32:0] LO = {1'b0, BASE};
    localparam logic [32:0] HI = {1'b0, BASE} + 33'(16 * NDEV);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;

    state_e          state_q;
    logic [IW-1:0]   idx_q;
    logic [CW-1:0]   cnt_q;
    logic [31:0]     pr_rd_q;
    logic            pr_ready_q;
    logic            pr_err_q;
    logic [NDEV-1:0] dev_sel_q;
    logic            dev_we_q;
    logic [1:0]      dev_addr_q;
    logic [31:0]     dev_wd_q;
    logic [3:0]      dev_be_q;
    logic [NDEV-1:0] irq_s1_q;
    logic [NDEV-1:0] irq_s2_q;

    logic [32:0]     addr_b;
    logic            hit;
    logic [IW-1:0]   idx_d;
    logic [31:0]     rd_sel;
    logic            rdy_sel;

    always_comb begin
        addr_b = {1'b0, pr_addr, 2'b00};
        hit    = (addr_b >= LO) && (addr_b < HI) &&
                 (32'(pr_addr[1:0]) < 32'(DEV_WORDS));
        idx_d  = IW'((addr_b - LO) >> 4);
    end

    // Only the latched device's data and ready are visible to the FSM
    always_comb begin
        rd_sel  = '0;
        rdy_sel = 1'b0;
        for (int i = 0; i < NDEV; i++) begin
            if (idx_q == IW'(i)) begin
                rd_sel  = dev_rd[32*i +: 32];
                rdy_sel = dev_ready[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            cnt_q      <= '0;
            pr_rd_q    <= '0;
            pr_ready_q <= 1'b0;
            pr_err_q   <= 1'b0;
            dev_sel_q  <= '0;
            dev_we_q   <= 1'b0;
            dev_addr_q <= '0;
            dev_wd_q   <= '0;
            dev_be_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pr_req) begin
                        if (hit) begin
                            dev_we_q   <= pr_we;
                            dev_addr_q <= pr_addr[1:0];
                            dev_wd_q   <= pr_wd;
                            dev_be_q   <= pr_be;
                            idx_q      <= idx_d;
                            dev_sel_q  <= NDEV'(1) << idx_d;
                            cnt_q      <= '0;
                            state_q    <= ACCESS;
                        end else begin
                            pr_rd_q    <= '0;
                            pr_ready_q <= 1'b1;
                            pr_err_q   <= 1'b1;
                            state_q    <= DONE;
                        end
                    end
                end
                ACCESS: begin
                    // Ready wins over timeout in the last allowed cycle
                    if (rdy_sel) begin
                        pr_rd_q    <= dev_we_q ? 32'h0 : rd_sel;
                        pr_ready_q <= 1'b1;
                        pr_err_q   <= 1'b0;
                        dev_sel_q  <= '0;
                        dev_we_q   <= 1'b0;
                        state_q    <= DONE;
                    end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                        pr_rd_q    <= '0;
                        pr_ready_q <= 1'b1;
                        pr_err_q   <= 1'b1;
                        dev_sel_q  <= '0;
                        dev_we_q   <= 1'b0;
                        state_q    <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    pr_ready_q <= 1'b0;
                    pr_err_q   <= 1'b0;
                    state_q    <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq_s1_q <= '0;
            irq_s2_q <= '0;
        end else begin
            irq_s1_q <= irq;
            irq_s2_q <= irq_s1_q;
        end
    end

    assign pr_rd    = pr_rd_q;
    assign pr_ready = pr_ready_q;
    assign pr_err   = pr_err_q;
    assign dev_sel  = dev_sel_q;
    assign dev_we   = dev_we_q;
    assign dev_addr = dev_addr_q;
    assign dev_wd   = dev_wd_q;
    assign dev_be   = dev_be_q;
    assign hw_int   = 6'(irq_s2_q);

endmodule

// File: tb/tb_sys_bridge_n.sv
// Bench for sys_bridge_n: directed and random transactions against a decode/latency
// model, reset abort, and IRQ synchroniser on NDEV=2 and NDEV=6 builds.
module tb_sys_bridge_n;
    localparam int          NDEV = 2;
    localparam logic [31:0] BASE = 32'h0000_7F00;
    localparam int          DW   = 3;
    localparam int          TO   = 16;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               pr_req = 1'b0, pr_we = 1'b0;
    logic [29:0]        pr_addr = '0;
    logic [31:0]        pr_wd = '0;
    logic [3:0]         pr_be = '0;
    logic [31:0]        pr_rd;
    logic               pr_ready, pr_err;
    logic [NDEV-1:0]    dev_sel;
    logic               dev_we;
    logic [1:0]         dev_addr;
    logic [31:0]        dev_wd;
    logic [3:0]         dev_be;
    logic [NDEV*32-1:0] dev_rd = '0;
    logic [NDEV-1:0]    dev_ready = '0;
    logic [NDEV-1:0]    irq = '0;
    logic [5:0]         hw_int;

    // NDEV=6 instance, used only for its interrupt path
    logic [5:0]   irq6 = '0;
    logic [5:0]   hw_int6, dev_sel6, dev_ready6;
    logic [191:0] dev_rd6;
    logic [31:0]  pr_rd6, dev_wd6;
    logic         pr_ready6, pr_err6, dev_we6;
    logic [1:0]   dev_addr6;
    logic [3:0]   dev_be6;
    assign dev_ready6 = '0;
    assign dev_rd6    = '0;

    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    sys_bridge_n #(.NDEV(NDEV), .BASE(BASE), .DEV_WORDS(DW), .TIMEOUT(TO)) u_dut (
        .clk(clk), .reset(reset), .pr_req(pr_req), .pr_we(pr_we), .pr_addr(pr_addr),
        .pr_wd(pr_wd), .pr_be(pr_be), .pr_rd(pr_rd), .pr_ready(pr_ready), .pr_err(pr_err),
        .dev_sel(dev_sel), .dev_we(dev_we), .dev_addr(dev_addr), .dev_wd(dev_wd),
        .dev_be(dev_be), .dev_rd(dev_rd), .dev_ready(dev_ready), .irq(irq), .hw_int(hw_int));

    sys_bridge_n #(.NDEV(6), .BASE(BASE), .DEV_WORDS(DW), .TIMEOUT(TO)) u_dut6 (
        .clk(clk), .reset(reset), .pr_req(1'b0), .pr_we(1'b0), .pr_addr(30'h0),
        .pr_wd(32'h0), .pr_be(4'h0), .pr_rd(pr_rd6), .pr_ready(pr_ready6), .pr_err(pr_err6),
        .dev_sel(dev_sel6), .dev_we(dev_we6), .dev_addr(dev_addr6), .dev_wd(dev_wd6),
        .dev_be(dev_be6), .dev_rd(dev_rd6), .dev_ready(dev_ready6), .irq(irq6), .hw_int(hw_int6));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Window decode from the address-map rules, in plain integer arithmetic
    function automatic void ref_decode(input logic [31:0] a_in, output bit hit, output int idx);
        longint a = longint'(a_in);
        longint b = longint'(BASE);
        hit = (a >= b) && (a < b + 16 * NDEV) && (((a / 4) % 4) < DW);
        idx = hit ? int'((a - b) / 16) : 0;
    endfunction

    // One CPU transaction; the device asserts ready in its delay-th ACCESS cycle
    task automatic txn(input string tag, input logic [31:0] baddr, input bit we,
                       input logic [31:0] wd, input logic [3:0] be, input int delay,
                       input logic [31:0] rdv);
        bit hit; int idx, lat; bit exp_err; logic [31:0] exp_rd; logic [NDEV-1:0] exp_sel;
        ref_decode(baddr, hit, idx);
        if (!hit)            begin lat = 1;         exp_err = 1'b1; exp_rd = '0; end
        else if (delay <= TO) begin lat = delay + 1; exp_err = 1'b0; exp_rd = we ? 32'h0 : rdv; end
        else                 begin lat = TO + 1;    exp_err = 1'b1; exp_rd = '0; end
        exp_sel = NDEV'(1) << idx;
        pr_req = 1'b1; pr_we = we; pr_addr = baddr[31:2]; pr_wd = wd; pr_be = be;
        dev_ready = '0; dev_rd = {$urandom, $urandom};
        for (int k = 1; k <= lat; k++) begin
            @(posedge clk); #1;
            if (k < lat) begin
                chk({tag, " busy"}, pr_ready, 0);
                chk({tag, " sel"}, dev_sel, exp_sel);
                chk({tag, " we"}, dev_we, we);
                chk({tag, " wd"}, dev_wd, wd);
                if (k == 1) begin
                    chk({tag, " addr"}, dev_addr, baddr[3:2]);
                    chk({tag, " be"}, dev_be, be);
                end
                dev_ready = NDEV'($urandom);
                dev_ready[idx] = (k == delay);
                dev_rd = {$urandom, $urandom};
                dev_rd[32*idx +: 32] = rdv;
            end else begin
                chk({tag, " ready"}, pr_ready, 1);
                chk({tag, " err"}, pr_err, exp_err);
                chk({tag, " rd"}, pr_rd, exp_rd);
                chk({tag, " sel_off"}, dev_sel, 0);
                chk({tag, " we_off"}, dev_we, 0);
            end
        end
        pr_req = 1'b0; dev_ready = '0;
        @(posedge clk); #1;
        chk({tag, " ready_drop"}, pr_ready, 0);
        chk({tag, " rd_hold"}, pr_rd, exp_rd);
    endtask

    initial begin
        logic [1:0] v2 [0:39];
        logic [5:0] v6 [0:39];
        bit         h; int ix;

        #2;
        chk("rst pr_rd", pr_rd, 0);       chk("rst pr_ready", pr_ready, 0);
        chk("rst pr_err", pr_err, 0);     chk("rst dev_sel", dev_sel, 0);
        chk("rst dev_we", dev_we, 0);     chk("rst dev_addr", dev_addr, 0);
        chk("rst dev_wd", dev_wd, 0);     chk("rst dev_be", dev_be, 0);
        chk("rst hw_int", hw_int, 0);
        repeat (2) @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        txn("rd_dev0", 32'h7F04, 1'b0, 32'h0, 4'hF, 1, 32'hDEADBEEF);
        txn("wr_dev1", 32'h7F18, 1'b1, 32'h12345678, 4'b1111, 3, 32'hCAFEF00D);
        txn("hole_off3", 32'h7F0C, 1'b0, 32'h0, 4'hF, 1, 32'h11111111);
        txn("hole_dev2", 32'h7F20, 1'b0, 32'h0, 4'hF, 1, 32'h22222222);
        txn("below_base", 32'h7EFC, 1'b1, 32'h5, 4'h1, 1, 32'h33333333);
        txn("top_mem", 32'hFFFFFFFC, 1'b0, 32'h0, 4'hF, 1, 32'h44444444);
        txn("timeout", 32'h7F00, 1'b0, 32'h0, 4'hF, 100, 32'h55555555);
        txn("after_to", 32'h7F14, 1'b0, 32'h0, 4'h3, 2, 32'h66666666);
        txn("ready_last", 32'h7F08, 1'b0, 32'h0, 4'hF, TO, 32'h77777777);
        txn("ready_late", 32'h7F10, 1'b1, 32'hABCD, 4'hC, TO + 1, 32'h88888888);

        // Reset while in ACCESS, between clock edges
        pr_req = 1'b1; pr_we = 1'b0; pr_addr = 30'(32'h7F04 >> 2); pr_be = 4'hF;
        repeat (3) @(posedge clk);
        #1; chk("pre_rst sel", dev_sel, 1);
        #3; reset = 1'b0;
        #1; chk("mid_rst sel", dev_sel, 0);
        chk("mid_rst ready", pr_ready, 0);
        pr_req = 1'b0;
        repeat (2) @(posedge clk); #1;
        reset = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            chk("post_rst ready", pr_ready, 0);
        end
        txn("post_rst_txn", 32'h7F04, 1'b0, 32'h0, 4'hF, 2, 32'h0BADF00D);

        for (int n = 0; n < 30; n++) begin
            logic [31:0] a;
            a = BASE + 32'(4 * (int'($urandom_range(0, 13)) - 2));
            ref_decode(a, h, ix);
            txn(h ? "rand_hit" : "rand_miss", a, 1'($urandom), $urandom, 4'($urandom),
                ($urandom_range(0, 7) == 0) ? 20 : int'($urandom_range(1, 6)), $urandom);
        end

        // hw_int after edge t reflects irq as sampled at edge t-1
        for (int s = 0; s < 40; s++) begin
            v2[s] = (s < 5) ? 2'b10 : (s < 8) ? 2'b00 : (s < 11) ? 2'b11 : 2'($urandom);
            v6[s] = (s < 5) ? 6'b100000 : (s < 8) ? 6'b0 : 6'($urandom);
        end
        for (int s = 0; s < 40; s++) begin
            irq = v2[s]; irq6 = v6[s];
            @(posedge clk); #1;
            chk("hw_int", hw_int, (s >= 1) ? {4'b0, v2[s-1]} : 6'b0);
            chk("hw_int6", hw_int6, (s >= 1) ? v6[s-1] : 6'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
